// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader and its receiver.
// The word-count saturation helper lives here so the header math stays in one place.
package uart_loader_pkg;

    localparam int DATA_WID          = 32;
    localparam int UART_LOAD_WORDS_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_DONE
    } ld_state_t;

    // Clamp the host-supplied word count so a corrupt header cannot overrun memory.
    function automatic logic [UART_LOAD_WORDS_W-1:0] sat_count(
        input logic [DATA_WID-1:0] count,
        input int                  max_words
    );
        if (count > DATA_WID'(max_words)) return UART_LOAD_WORDS_W'(max_words);
        return count[UART_LOAD_WORDS_W-1:0];
    endfunction

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch rejection on the start bit,
// and a frame-error pulse when the stop bit is low.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             stop_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            stop_wait  <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here, so every branch sees the pre-edge values.
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(CPB - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // After a bad stop bit, hold off until the line idles so a stuck-low rx is not read as a start.
                    if (stop_wait) begin
                        if (rx_sync) begin
                            stop_wait <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (cnt == CNT_W'(CPB - 1)) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            byte_out   <= shreg;
                            byte_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            stop_wait <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: reads a little-endian word count, then streams 32-bit words with
// byte addresses to memory and raises uart_done to release the core.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int                  CLK_FREQ  = 50_000_000,
    parameter int                  BAUD      = 115_200,
    parameter logic [DATA_WID-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                  MAX_WORDS = 16384
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic [DATA_WID-1:0]          uart_data,
    output logic [DATA_WID-1:0]          uart_addr,
    output logic                         uart_wr,
    output logic                         uart_done,
    output logic                         frame_err,
    output logic [UART_LOAD_WORDS_W-1:0] words_loaded
);

    logic [7:0]                   rx_byte;
    logic                         rx_valid;
    ld_state_t                    state;
    logic [1:0]                   byte_idx;
    logic [23:0]                  asm_word;
    logic [UART_LOAD_WORDS_W-1:0] n_words;
    logic                         done_arm;
    logic [DATA_WID-1:0]          full_word;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_out   (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (frame_err)
    );

    // The 4th byte goes straight to the top lane, so the word is complete in the same cycle it arrives.
    assign full_word = {rx_byte, asm_word};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LEN;
            byte_idx     <= '0;
            asm_word     <= '0;
            n_words      <= '0;
            done_arm     <= 1'b0;
            uart_data    <= '0;
            uart_addr    <= BASE_ADDR;
            uart_wr      <= 1'b0;
            uart_done    <= 1'b0;
            words_loaded <= '0;
        end else begin
            uart_wr <= 1'b0;
            case (state)
                S_LEN: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            n_words <= sat_count(full_word, MAX_WORDS);
                            state   <= (sat_count(full_word, MAX_WORDS) == '0) ? S_DONE : S_DATA;
                        end else begin
                            asm_word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            uart_data    <= full_word;
                            uart_addr    <= BASE_ADDR + DATA_WID'({words_loaded, 2'b00});
                            uart_wr      <= 1'b1;
                            words_loaded <= words_loaded + 1'b1;
                            if (words_loaded + 1'b1 == n_words) state <= S_DONE;
                        end else begin
                            asm_word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        end
                    end
                end
                S_DONE: begin
                    // Two-stage delay keeps the last word on the memory port for a cycle before the core owns it.
                    done_arm <= 1'b1;
                    if (done_arm) uart_done <= 1'b1;
                end
                default: state <= S_LEN;
            endcase
        end
    end

endmodule
